mem_access_unit: RTL and testbench

- Memory-side responder for the multicycle controller's memory strobes.
- Accepts instruction-fetch (IRWrite), data read (MemRead) and data write (MemWrite) requests with a 16-bit address.
- Performs each access against a synchronous single-port SRAM with a fixed number of wait states.
- Returns a one-cycle mem_ready, a registered instruction (IR) and a registered memory data register (MDR).

---
 rtl/proc16_pkg.sv | 31 +++
 rtl/mem_access_unit_if.sv | 58 +++++
 rtl/mem_wait_counter.sv | 34 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/proc16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proc16_pkg                                                                 |
// | Encodings and default widths shared by the proc16 datapath and memory unit.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package proc16_pkg;

  localparam int P16_ADDR_W = 16;
  localparam int P16_DATA_W = 16;
  localparam int WCNT_W     = 4;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'b00,
    MEM_ACCESS = 2'b01,
    MEM_DONE   = 2'b10
  } mem_state_t;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'b00,
    ACC_READ  = 2'b01,
    ACC_WRITE = 2'b10
  } acc_type_t;

  // Event counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_if / mem_sram_if                                                   |
// | Requester-side and SRAM-side buses of mem_access_unit.                     |
// | MEM_ACCESS_STATS_EN adds the fetch/read/write counters to mem_req_if.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_req_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              IRWrite;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              mem_ready;
  logic              busy;
  logic              req_err;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] mdr;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0]       fetch_cnt;
  logic [15:0]       rd_cnt;
  logic [15:0]       wr_cnt;
`endif

  modport master (
    output IRWrite, MemRead, MemWrite, addr, wdata,
    input  mem_ready, busy, req_err, instr, mdr
`ifdef MEM_ACCESS_STATS_EN
    , input fetch_cnt, rd_cnt, wr_cnt
`endif
  );

  modport slave (
    input  IRWrite, MemRead, MemWrite, addr, wdata,
    output mem_ready, busy, req_err, instr, mdr
`ifdef MEM_ACCESS_STATS_EN
    , output fetch_cnt, rd_cnt, wr_cnt
`endif
  );
endinterface

interface mem_sram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wait_counter                                                           |
// | Loadable 4-bit down-counter; last flags the final wait-state cycle.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_wait_counter
  import proc16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [WCNT_W-1:0] load_val,
  output logic              last
);

  logic [WCNT_W-1:0] count;

  // Floors at zero so a stray enable after the last cycle cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == WCNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | Serves fetch/read/write strobes against a fixed-wait synchronous SRAM.     |
// | MEM_ACCESS_STATS_EN adds saturating per-type completion counters.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit
  import proc16_pkg::*;
#(
  parameter int ADDR_W      = P16_ADDR_W,
  parameter int DATA_W      = P16_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_req_if.slave   req,
  mem_sram_if.master sram
);

  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES);

  mem_state_t        state;
  mem_state_t        state_nxt;
  acc_type_t         acc_type;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic              req_err_reg;
  logic [1:0]        req_cnt;
  logic              single_req;
  logic              multi_req;
  logic              cnt_last;
  logic              in_access;
  logic              in_done;

  assign req_cnt    = {1'b0, req.IRWrite} + {1'b0, req.MemRead} + {1'b0, req.MemWrite};
  assign single_req = (state == MEM_IDLE) && (req_cnt == 2'd1);
  assign multi_req  = (state == MEM_IDLE) && (req_cnt > 2'd1);

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (single_req),
    .en       (in_access),
    .load_val (WAIT_LOAD),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_access = 1'b0;
    in_done   = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (single_req) state_nxt = MEM_ACCESS;
      end
      MEM_ACCESS: begin
        in_access = 1'b1;
        if (cnt_last) state_nxt = MEM_DONE;
      end
      MEM_DONE: begin
        in_done   = 1'b1;
        state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; later bus changes cannot disturb the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_type  <= ACC_FETCH;
      addr_lat  <= '0;
      wdata_lat <= '0;
    end else if (single_req) begin
      addr_lat  <= req.addr;
      wdata_lat <= req.wdata;
      if (req.MemWrite) begin
        acc_type <= ACC_WRITE;
      end else if (req.MemRead) begin
        acc_type <= ACC_READ;
      end else begin
        acc_type <= ACC_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg <= '0;
      mdr_reg   <= '0;
    end else if (in_access && cnt_last) begin
      if (acc_type == ACC_FETCH) instr_reg <= sram.rdata;
      if (acc_type == ACC_READ)  mdr_reg   <= sram.rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_err_reg <= 1'b0;
    end else begin
      req_err_reg <= multi_req;
    end
  end

  assign sram.en    = in_access;
  assign sram.we    = in_access && (acc_type == ACC_WRITE);
  assign sram.addr  = addr_lat;
  assign sram.wdata = wdata_lat;

  assign req.mem_ready = in_done;
  assign req.busy      = (state != MEM_IDLE);
  assign req.req_err   = req_err_reg;
  assign req.instr     = instr_reg;
  assign req.mdr       = mdr_reg;

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else if (in_done) begin
      case (acc_type)
        ACC_FETCH: fetch_cnt <= sat_inc16(fetch_cnt);
        ACC_READ:  rd_cnt    <= sat_inc16(rd_cnt);
        ACC_WRITE: wr_cnt    <= sat_inc16(wr_cnt);
        default:   ;
      endcase
    end
  end

  assign req.fetch_cnt = fetch_cnt;
  assign req.rd_cnt    = rd_cnt;
  assign req.wr_cnt    = wr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                         |
// | Vector table with scoreboard on a WAIT_CYCLES=2 unit, plus reset-abort and |
// | WAIT_CYCLES=1 sequences; counters checked when MEM_ACCESS_STATS_EN is set. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int         W0        = 2;
  localparam logic [1:0] K_FETCH   = 2'd0;
  localparam logic [1:0] K_READ    = 2'd1;
  localparam logic [1:0] K_WRITE   = 2'd2;
  localparam logic [1:0] K_ILLEGAL = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] mdr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_if  rq  ();
  mem_sram_if sr  ();
  mem_req_if  rq1 ();
  mem_sram_if sr1 ();

  mem_access_unit #(.WAIT_CYCLES(W0)) u_dut  (.clk(clk), .rst(rst), .req(rq),  .sram(sr));
  mem_access_unit #(.WAIT_CYCLES(1))  u_dut1 (.clk(clk), .rst(rst), .req(rq1), .sram(sr1));

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] exp_instr = 16'h0;
  logic [15:0] exp_mdr   = 16'h0;
  int   n_fetch = 0, n_read = 0, n_write = 0;
  vec_t tbl[11];
  vec_t seq1[6];

  // SRAM models: combinational read, write on the clock edge; unwritten words read a fixed pattern.
  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h8123 : (a ^ 16'hA5A5);
  endfunction

  logic [15:0] mem0 [256];
  bit          val0 [256];
  logic [15:0] mem1 [256];
  bit          val1 [256];
  assign sr.rdata  = val0[sr.addr[7:0]]  ? mem0[sr.addr[7:0]]  : dflt(sr.addr);
  assign sr1.rdata = val1[sr1.addr[7:0]] ? mem1[sr1.addr[7:0]] : dflt(sr1.addr);
  always @(posedge clk) begin
    if (sr.en && sr.we) begin
      mem0[sr.addr[7:0]] <= sr.wdata;
      val0[sr.addr[7:0]] <= 1'b1;
    end
    if (sr1.en && sr1.we) begin
      mem1[sr1.addr[7:0]] <= sr1.wdata;
      val1[sr1.addr[7:0]] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rq.mem_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_mem_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", {16'h0, rq.instr}, {16'h0, e.instr});
        check("sb_mdr",   {16'h0, rq.mdr},   {16'h0, e.mdr});
      end
    end
  end

  task automatic drive(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] d);
    rq.IRWrite  = (kind == K_FETCH);
    rq.MemRead  = (kind == K_READ)  || (kind == K_ILLEGAL);
    rq.MemWrite = (kind == K_WRITE) || (kind == K_ILLEGAL);
    rq.addr     = a;
    rq.wdata    = d;
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    int   lat, en_n, we_n, bad;
    @(negedge clk);
    drive(v.kind, v.addr, v.wdata);
    if (v.kind == K_FETCH) exp_instr = v.exp;
    if (v.kind == K_READ)  exp_mdr   = v.exp;
    if (v.kind != K_ILLEGAL) begin
      e.instr = exp_instr;
      e.mdr   = exp_mdr;
      sb.push_back(e);
      if (v.kind == K_FETCH) n_fetch++;
      if (v.kind == K_READ)  n_read++;
      if (v.kind == K_WRITE) n_write++;
    end
    @(negedge clk);
    drive(K_FETCH, 16'h0, 16'h0);
    rq.IRWrite = 1'b0;
    if (v.kind == K_ILLEGAL) begin
      check("illegal_req_err", {31'h0, rq.req_err}, 32'd1);
      check("illegal_sram_en", {31'h0, sr.en},      32'd0);
      check("illegal_busy",    {31'h0, rq.busy},    32'd0);
      @(negedge clk);
      check("illegal_req_err_pulse", {31'h0, rq.req_err}, 32'd0);
      check("illegal_sram_en2",      {31'h0, sr.en},      32'd0);
      return;
    end
    lat = 1; en_n = 0; we_n = 0; bad = 0;
    while (!rq.mem_ready && lat < 20) begin
      if (sr.en) en_n++;
      if (sr.we) we_n++;
      if (sr.en && (sr.addr !== v.addr)) bad++;
      if (sr.we && (sr.wdata !== v.wdata)) bad++;
      if (!rq.busy) bad++;
      @(negedge clk);
      lat++;
    end
    check("latency",      lat,  W0 + 1);
    check("sram_en_cyc",  en_n, W0);
    check("sram_we_cyc",  we_n, (v.kind == K_WRITE) ? W0 : 0);
    check("sram_bus",     bad,  0);
    check("done_sram_en", {31'h0, sr.en},   32'd0);
    check("done_busy",    {31'h0, rq.busy}, 32'd1);
    @(negedge clk);
    check("ready_pulse",  {31'h0, rq.mem_ready}, 32'd0);
    check("idle_busy",    {31'h0, rq.busy},      32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'h0, rq.mem_ready, rq.busy, rq.req_err, sr.en, sr.we, 1'b0}, 32'd0);
    check({tag, "_instr_mdr"}, {rq.instr, rq.mdr}, 32'd0);
    check({tag, "_sram_addr_wdata"}, {sr.addr, sr.wdata}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, en_n;
    tbl[0]  = '{K_FETCH,   16'h0010, 16'h0000, 16'h8123};
    tbl[1]  = '{K_WRITE,   16'h0040, 16'hBEEF, 16'h0000};
    tbl[2]  = '{K_READ,    16'h0040, 16'h0000, 16'hBEEF};
    tbl[3]  = '{K_READ,    16'h0010, 16'h0000, 16'h8123};
    tbl[4]  = '{K_WRITE,   16'h0011, 16'h1234, 16'h0000};
    tbl[5]  = '{K_FETCH,   16'h0011, 16'h0000, 16'h1234};
    tbl[6]  = '{K_ILLEGAL, 16'h0020, 16'h5555, 16'h0000};
    tbl[7]  = '{K_WRITE,   16'h0040, 16'hCAFE, 16'h0000};
    tbl[8]  = '{K_FETCH,   16'h0040, 16'h0000, 16'hCAFE};
    tbl[9]  = '{K_READ,    16'h00FF, 16'h0000, 16'hA55A};
    tbl[10] = '{K_FETCH,   16'h0020, 16'h0000, 16'hA585};

    seq1[0] = '{K_WRITE, 16'h0005, 16'h7777, 16'h0000};
    seq1[1] = '{K_READ,  16'h0005, 16'h0000, 16'h7777};
    seq1[2] = '{K_READ,  16'h0010, 16'h0000, 16'h8123};
    seq1[3] = '{K_FETCH, 16'h0005, 16'h0000, 16'h7777};
    seq1[4] = '{K_FETCH, 16'h0010, 16'h0000, 16'h8123};
    seq1[5] = '{K_FETCH, 16'h00FF, 16'h0000, 16'hA55A};

    drive(K_FETCH, 16'h0, 16'h0);
    rq.IRWrite   = 1'b0;
    rq1.IRWrite  = 1'b0;
    rq1.MemRead  = 1'b0;
    rq1.MemWrite = 1'b0;
    rq1.addr     = 16'h0;
    rq1.wdata    = 16'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 11; i++) issue(tbl[i]);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
`ifdef MEM_ACCESS_STATS_EN
    check("stats_fetch", {16'h0, rq.fetch_cnt}, n_fetch);
    check("stats_read",  {16'h0, rq.rd_cnt},    n_read);
    check("stats_write", {16'h0, rq.wr_cnt},    n_write);
`endif

    // Reset lands in the first ACCESS cycle of a write; the write must vanish.
    @(negedge clk);
    drive(K_WRITE, 16'h0040, 16'h1111);
    @(negedge clk);
    drive(K_FETCH, 16'h0, 16'h0);
    rq.IRWrite = 1'b0;
    check("abort_pre_en", {31'h0, sr.we}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    exp_instr = 16'h0;
    exp_mdr   = 16'h0;
    repeat (4) @(negedge clk);
    check("abort_no_ready", {31'h0, rq.busy}, 32'd0);
    issue('{K_READ, 16'h0040, 16'h0000, 16'hCAFE});
    check("abort_instr_kept", {16'h0, rq.instr}, 32'd0);

    // Single wait-state unit: one ACCESS cycle, mem_ready two cycles after the request.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rq1.IRWrite  = (seq1[i].kind == K_FETCH);
      rq1.MemRead  = (seq1[i].kind == K_READ);
      rq1.MemWrite = (seq1[i].kind == K_WRITE);
      rq1.addr     = seq1[i].addr;
      rq1.wdata    = seq1[i].wdata;
      @(negedge clk);
      rq1.IRWrite  = 1'b0;
      rq1.MemRead  = 1'b0;
      rq1.MemWrite = 1'b0;
      lat = 1; en_n = 0;
      while (!rq1.mem_ready && lat < 20) begin
        if (sr1.en) en_n++;
        @(negedge clk);
        lat++;
      end
      check("w1_latency", lat, 2);
      check("w1_en_cyc", en_n, 1);
      if (seq1[i].kind == K_FETCH) check("w1_instr", {16'h0, rq1.instr}, {16'h0, seq1[i].exp});
      if (seq1[i].kind == K_READ)  check("w1_mdr",   {16'h0, rq1.mdr},   {16'h0, seq1[i].exp});
      @(negedge clk);
    end
    check("w1_mdr_after_fetch", {16'h0, rq1.mdr}, 32'h8123);
`ifdef MEM_ACCESS_STATS_EN
    check("w1_stats_fetch", {16'h0, rq1.fetch_cnt}, 32'd3);
    check("w1_stats_read",  {16'h0, rq1.rd_cnt},    32'd2);
    check("w1_stats_write", {16'h0, rq1.wr_cnt},    32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
